// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one BRAM port among NUM_REQ requesters using round-robin arbitration.
// One command is accepted per cycle. The BRAM-side command is registered.
// Read data comes back with a fixed latency: a read accepted at edge E0 raises
// its rd_valid_o bit for the single cycle after edge E0+2.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid_i     per-requester command valid
//   req_ready_o     one-hot grant (combinational), zero while rst is high
//   req_wen_i       per-requester write(1)/read(0)
//   req_be_i        per-requester byte enables, slice k = requester k
//   req_addr_i      per-requester address, slice k = requester k
//   req_wdata_i     per-requester write data, slice k = requester k
//   rd_valid_o      one-hot read-return strobe
//   rd_data_o       shared read data (BRAM data passed through)
//   ram_*_o         registered BRAM command
//   ram_rdata_i     BRAM read data, valid one clock after a sampled read enable
//   busy_o          at least one read is still in flight
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int BE_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0]             req_wen_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]    req_be_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]             rd_valid_o,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           ram_wen_o,
  output logic                           ram_ren_o,
  output logic [BE_WIDTH-1:0]            ram_be_o,
  output logic [ADDR_WIDTH-1:0]          ram_addr_o,
  output logic [DATA_WIDTH-1:0]          ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]          ram_rdata_i,
  output logic                           busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ptr_next;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [NUM_REQ-1:0]    ready;
  logic [IDX_W-1:0]      ram_idx;
  logic [IDX_W-1:0]      tag_idx;
  logic                  tag_valid;
  logic [NUM_REQ-1:0]    tag_dec;
  logic                  sel_wen;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  int                    cand;

  // Round-robin search: first valid requester at or above ptr, with wrap-around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!grant_any && req_valid_i[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end else begin
        grant_any = grant_any;
      end
    end
    // Nothing may be accepted while reset is held.
    if (rst) begin
      grant_any = 1'b0;
    end else begin
      grant_any = grant_any;
    end
  end

  // One-hot ready from the granted index.
  always_comb begin
    ready = '0;
    if (grant_any) begin
      ready[grant_idx] = 1'b1;
    end else begin
      ready = '0;
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  // One-hot decode of the read tag, gated by the captured read enable.
  always_comb begin
    tag_dec = '0;
    if (tag_valid) begin
      tag_dec[tag_idx] = 1'b1;
    end else begin
      tag_dec = '0;
    end
  end

  assign sel_wen     = req_wen_i[grant_idx];
  assign sel_be      = req_be_i[int'(grant_idx)*BE_WIDTH +: BE_WIDTH];
  assign sel_addr    = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata   = req_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign req_ready_o = ready;
  assign rd_data_o   = ram_rdata_i;

  // Command register, read-tag pipeline, return strobe and busy flag.
  // Stages for a read accepted at E0: ram_ren_o after E0, tag after E0+1,
  // rd_valid_o after E0+2 (lining up with BRAM data).
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      ram_wen_o   <= 1'b0;
      ram_ren_o   <= 1'b0;
      ram_be_o    <= '0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_idx     <= '0;
      tag_idx     <= '0;
      tag_valid   <= 1'b0;
      rd_valid_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      if (grant_any) begin
        ptr         <= ptr_next;
        ram_wen_o   <= sel_wen;
        ram_ren_o   <= ~sel_wen;
        ram_be_o    <= sel_be;
        ram_addr_o  <= sel_addr;
        ram_wdata_o <= sel_wdata;
        ram_idx     <= grant_idx;
      end else begin
        ram_wen_o   <= 1'b0;
        ram_ren_o   <= 1'b0;
      end
      tag_idx    <= ram_idx;
      tag_valid  <= ram_ren_o;
      rd_valid_o <= tag_dec;
      // Any read in one of the three pipeline positions keeps busy high.
      busy_o     <= (grant_any & ~sel_wen) | ram_ren_o | tag_valid;
    end
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one BRAM port (range 2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the BRAM port address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 18, giving the BRAM port data width.
REQ-004 The block SHALL have parameter BE_WIDTH, default 2, giving the write byte-enable width.
REQ-005 The block SHALL have one clock and a synchronous active-high reset, named as follows:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have the following requester-side ports, with bit or slice k belonging to requester k:
- req_valid_i  input  NUM_REQ  requester k presents a command.
- req_ready_o  output  NUM_REQ  command k is accepted this cycle.
- req_wen_i  input  NUM_REQ  1 = write, 0 = read.
- req_be_i  input  NUM_REQ*BE_WIDTH  write byte enables.
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  address.
- req_wdata_i  input  NUM_REQ*DATA_WIDTH  write data.
- rd_valid_o  output  NUM_REQ  read data for requester k is valid this cycle.
- rd_data_o  output  DATA_WIDTH  read data, shared by all requesters.
REQ-007 The block SHALL have the following BRAM-side ports:
- ram_wen_o  output  1  write enable.
- ram_ren_o  output  1  read enable.
- ram_be_o  output  BE_WIDTH  byte enables.
- ram_addr_o  output  ADDR_WIDTH  address.
- ram_wdata_o  output  DATA_WIDTH  write data.
- ram_rdata_i  input  DATA_WIDTH  BRAM read data, valid one clock after a sampled read enable.
- busy_o  output  1  a read is in flight.

Function
REQ-008 A command from requester k SHALL be accepted on any rising edge at which req_valid_i[k] and req_ready_o[k] are both high.
REQ-009 req_ready_o SHALL be combinational, one-hot or zero, and SHALL have exactly one bit set whenever any req_valid_i bit is high and rst is low.
REQ-010 Arbitration SHALL be round-robin: the granted requester is the first valid requester found searching upward, with wrap-around, starting at the priority pointer.
REQ-011 After each acceptance from requester k, the priority pointer SHALL become (k+1) mod NUM_REQ; when no command is accepted the pointer SHALL hold.
REQ-012 The BRAM outputs SHALL be registered. On the edge that accepts a command:
- ram_wen_o takes the command's wen.
- ram_ren_o takes the inverse of the command's wen.
- ram_be_o, ram_addr_o and ram_wdata_o take the command's fields.
REQ-013 On an edge with no acceptance, ram_wen_o and ram_ren_o SHALL go to 0, and ram_be_o, ram_addr_o and ram_wdata_o SHALL hold their previous values.
REQ-014 A tag register SHALL capture the requester index and the ram_ren_o value on every edge; rd_valid_o SHALL be the one-hot decode of the tag, gated by the captured ram_ren_o.
REQ-015 rd_data_o SHALL equal ram_rdata_i combinationally.
REQ-016 Read latency SHALL be fixed: a read accepted at edge E0 has rd_valid_o high for exactly the one cycle following edge E0+2.
REQ-017 At most one rd_valid_o bit SHALL be high in any cycle.
REQ-018 Writes SHALL never produce an rd_valid_o pulse.
REQ-019 Throughput SHALL be one command per cycle with no bubbles, including back-to-back reads from different requesters and read-after-write to the same address.
REQ-020 busy_o SHALL be high while any read has been accepted but its rd_valid_o pulse has not yet completed.
REQ-021 A requester whose req_valid_i is deasserted before acceptance SHALL have no command issued on its behalf.
REQ-022 Each requester's command fields SHALL be allowed to change only after acceptance.

Reset
REQ-023 While rst is high, req_ready_o SHALL be all zeros and no command SHALL be accepted.
REQ-024 On a reset edge:
- ram_wen_o, ram_ren_o and ram_be_o go to 0.
- ram_addr_o and ram_wdata_o go to 0.
- the tag register, rd_valid_o and busy_o clear to 0.
- the priority pointer goes to 0.
REQ-025 Reads in flight when reset is asserted SHALL be discarded, and no rd_valid_o pulse SHALL follow reset release for them.

Verification
REQ-026 Reset release, requester 2 only: read addr 0x005 holding 0x2A5A5 -> ram_ren_o=1 with ram_addr_o=0x005 one cycle after acceptance; rd_valid_o=4'b0100 with rd_data_o=0x2A5A5 two cycles after that edge, for exactly one cycle.
REQ-027 All four requesters hold valid continuously from reset -> grants in the order 0,1,2,3,0,1,...; one acceptance per cycle; no requester waits more than 3 cycles.
REQ-028 Requester 1 writes 0x3FFFF to addr 0x3FF with be=2'b01, then requester 3 reads 0x3FF in the next cycle -> ram_be_o=2'b01 on the write; rd_valid_o=4'b1000 with the model's merged data.
REQ-029 rst asserted for one cycle in the cycle after a read is accepted -> no rd_valid_o pulse and busy_o=0 after reset; the pointer restarts at requester 0.
REQ-030 Random valid/withdraw traffic on all requesters, scoreboard against a 1024x18 memory model -> every read returns model data; no rd_valid_o for writes; grants match the round-robin reference.
